// File: rtl/ddr_arbiter.sv
// Arbiter for the single DDR command path shared by video reads, draw writes and auto-refresh.
// One op is in flight at a time: grant in IDLE, present in ISSUE, wait for ddrDone in WAIT_DONE.
module ddr_arbiter #(
  parameter int addrWidth       = 24,
  parameter int refreshInterval = 1037,
  parameter int starveLimit     = 8
) (
  input  logic                 clk133_p,
  input  logic                 rst,
  input  logic                 initComplete,
  input  logic                 vidReq,
  input  logic [addrWidth-1:0] vidAddr,
  output logic                 vidAck,
  output logic                 vidValid,
  output logic [31:0]          vidData,
  input  logic                 drawReq,
  input  logic [addrWidth-1:0] drawAddr,
  input  logic [31:0]          drawData,
  output logic                 drawAck,
  output logic                 ddrValid,
  output logic                 ddrWrite,
  output logic                 ddrRefresh,
  output logic [addrWidth-1:0] ddrAddr,
  output logic [31:0]          ddrData,
  input  logic                 ddrReady,
  input  logic                 ddrDone,
  input  logic [31:0]          ddrReadData,
  output logic                 refreshOverrun
);

  localparam int REF_W = (refreshInterval > 1) ? $clog2(refreshInterval) : 1;
  localparam int STV_W = $clog2(starveLimit + 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(refreshInterval - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(starveLimit);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]           r_state;
  logic [REF_W-1:0]     r_refCnt;
  logic                 r_refPend;
  logic                 r_overrun;
  logic [STV_W-1:0]     r_starve;
  logic                 r_opRef;
  logic                 r_opWrite;
  logic                 r_opVid;
  logic [addrWidth-1:0] r_opAddr;
  logic [31:0]          r_opData;
  logic                 r_vidAck;
  logic                 r_drawAck;
  logic                 r_vidValid;
  logic [31:0]          r_vidData;

  logic w_grantRef;
  logic w_grantDraw;
  logic w_grantVid;
  logic w_wrap;
  logic w_accept;
  logic w_done;

  // Decision uses registered refresh/starve state only, so a wrap in the same
  // cycle as a grant leaves the requester the winner.
  always_comb begin
    w_grantRef  = 1'b0;
    w_grantDraw = 1'b0;
    w_grantVid  = 1'b0;
    if (r_state == S_IDLE && initComplete) begin
      if (r_refPend)                          w_grantRef  = 1'b1;
      else if (drawReq && r_starve == STV_MAX) w_grantDraw = 1'b1;
      else if (vidReq)                        w_grantVid  = 1'b1;
      else if (drawReq)                       w_grantDraw = 1'b1;
    end
  end

  assign w_wrap   = initComplete && (r_refCnt == REF_LAST);
  assign w_accept = (r_state == S_ISSUE) && ddrReady;
  assign w_done   = (r_state == S_WAIT) && ddrDone;

  always_ff @(posedge clk133_p) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_refCnt   <= '0;
      r_refPend  <= 1'b0;
      r_overrun  <= 1'b0;
      r_starve   <= '0;
      r_opRef    <= 1'b0;
      r_opWrite  <= 1'b0;
      r_opVid    <= 1'b0;
      r_opAddr   <= '0;
      r_opData   <= '0;
      r_vidAck   <= 1'b0;
      r_drawAck  <= 1'b0;
      r_vidValid <= 1'b0;
      r_vidData  <= '0;
    end else begin
      r_vidAck   <= w_grantVid;
      r_drawAck  <= w_grantDraw;
      r_vidValid <= w_done && r_opVid;
      if (w_done && r_opVid) r_vidData <= ddrReadData;

      if (!initComplete || w_wrap) r_refCnt <= '0;
      else                         r_refCnt <= r_refCnt + REF_W'(1);

      // A new interval elapsing outranks the clear of the refresh being accepted.
      if (w_wrap)                    r_refPend <= 1'b1;
      else if (w_accept && r_opRef)  r_refPend <= 1'b0;
      if (w_wrap && r_refPend)       r_overrun <= 1'b1;

      if (!drawReq || w_grantDraw)              r_starve <= '0;
      else if (w_grantVid && r_starve != STV_MAX) r_starve <= r_starve + STV_W'(1);

      case (r_state)
        S_IDLE: begin
          if (w_grantRef || w_grantDraw || w_grantVid) begin
            r_state   <= S_ISSUE;
            r_opRef   <= w_grantRef;
            r_opWrite <= w_grantDraw;
            r_opVid   <= w_grantVid;
            r_opAddr  <= w_grantVid ? vidAddr : (w_grantDraw ? drawAddr : '0);
            r_opData  <= w_grantDraw ? drawData : '0;
          end
        end
        S_ISSUE: if (ddrReady) r_state <= S_WAIT;
        S_WAIT:  if (ddrDone)  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ddrValid       = (r_state == S_ISSUE);
  assign ddrWrite       = r_opWrite;
  assign ddrRefresh     = r_opRef;
  assign ddrAddr        = r_opAddr;
  assign ddrData        = r_opData;
  assign vidAck         = r_vidAck;
  assign drawAck        = r_drawAck;
  assign vidValid       = r_vidValid;
  assign vidData        = r_vidData;
  assign refreshOverrun = r_overrun;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Bench for ddr_arbiter: randomized requesters and controller against a transaction-level
// model of the arbitration rules, plus directed scenario checks.
module tb_ddr_arbiter;
  localparam int AW      = 24;
  localparam int REF_INT = 1037;
  localparam int STARVE  = 8;
  localparam int K_VID = 0, K_DRAW = 1, K_REF = 2;

  logic          clk133_p = 1'b0;
  logic          rst, initComplete, vidReq, drawReq, ddrReady, ddrDone;
  logic [AW-1:0] vidAddr, drawAddr;
  logic [31:0]   drawData, ddrReadData;
  logic          vidAck, vidValid, drawAck, ddrValid, ddrWrite, ddrRefresh, refreshOverrun;
  logic [31:0]   vidData, ddrData;
  logic [AW-1:0] ddrAddr;

  always #4 clk133_p = ~clk133_p;

  ddr_arbiter #(.addrWidth(AW), .refreshInterval(REF_INT), .starveLimit(STARVE)) dut (
    .clk133_p(clk133_p), .rst(rst), .initComplete(initComplete),
    .vidReq(vidReq), .vidAddr(vidAddr), .vidAck(vidAck), .vidValid(vidValid), .vidData(vidData),
    .drawReq(drawReq), .drawAddr(drawAddr), .drawData(drawData), .drawAck(drawAck),
    .ddrValid(ddrValid), .ddrWrite(ddrWrite), .ddrRefresh(ddrRefresh), .ddrAddr(ddrAddr),
    .ddrData(ddrData), .ddrReady(ddrReady), .ddrDone(ddrDone), .ddrReadData(ddrReadData),
    .refreshOverrun(refreshOverrun)
  );

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } op_t;

  int checks, errors, cyc;
  // stimulus knobs
  int readyMode, doneDelay;
  bit spurDone, vidHold, drawHold, vidRand, drawRand, rdFixed;
  logic [31:0] rdVal;
  // controller responder
  int doneCnt, lastDoneCyc;
  bit outstanding;
  // reference model
  op_t  mOp;
  bit   mIssued, mWaiting, mRefPend, mOverrun, expVidAck, expDrawAck, expVidValid;
  logic [31:0] mVidData;
  int   nInit, vidWhileDrawWaits;
  bit   prevValid;
  int   grantLog[$];
  int   refCyc[$];

  // Advance the model over the edge that ends the current cycle, using this cycle's inputs.
  task automatic model_update();
    bit wrap, idle, vidG, drawG, refG, accRef;
    wrap = 0; vidG = 0; drawG = 0; refG = 0; accRef = 0;
    expVidAck = 0; expDrawAck = 0; expVidValid = 0;
    if (!rst) begin
      mIssued = 0; mWaiting = 0; mRefPend = 0; mOverrun = 0; nInit = 0;
      vidWhileDrawWaits = 0; mVidData = '0;
    end else begin
      if (initComplete) begin
        nInit++;
        wrap = (nInit % REF_INT) == 0;
      end else nInit = 0;
      idle = !mIssued && !mWaiting;
      if (mWaiting && ddrDone) begin
        mWaiting = 0;
        if (mOp.kind == K_VID) begin expVidValid = 1; mVidData = ddrReadData; end
      end else if (mIssued && ddrReady) begin
        mIssued = 0; mWaiting = 1; accRef = (mOp.kind == K_REF);
      end else if (idle && initComplete) begin
        if (mRefPend) refG = 1;
        else if (drawReq && vidWhileDrawWaits >= STARVE) drawG = 1;
        else if (vidReq) vidG = 1;
        else if (drawReq) drawG = 1;
      end
      if (refG)  begin mOp.kind = K_REF;  mOp.addr = '0;       mOp.data = '0;       mIssued = 1; end
      if (vidG)  begin mOp.kind = K_VID;  mOp.addr = vidAddr;  mOp.data = '0;       mIssued = 1; expVidAck = 1; end
      if (drawG) begin mOp.kind = K_DRAW; mOp.addr = drawAddr; mOp.data = drawData; mIssued = 1; expDrawAck = 1; end
      if (!drawReq || drawG) vidWhileDrawWaits = 0;
      else if (vidG) vidWhileDrawWaits++;
      if (wrap && mRefPend) mOverrun = 1;
      mRefPend = (mRefPend && !accRef) || wrap;
    end
  endtask

  // One clock cycle: update model, observe DUT mid-cycle, compare, then drive next inputs.
  task automatic step();
    model_update();
    @(negedge clk133_p);
    cyc++;
    checks++;
    if (ddrValid !== mIssued) begin
      errors++; $display("FAIL ddrValid cyc %0d got %b exp %b", cyc, ddrValid, mIssued);
    end
    if (mIssued) begin
      checks++;
      if (ddrRefresh !== (mOp.kind == K_REF) || ddrWrite !== (mOp.kind == K_DRAW) || ddrAddr !== mOp.addr) begin
        errors++;
        $display("FAIL op_fields cyc %0d got ref=%b wr=%b addr=%h exp ref=%0b wr=%0b addr=%h",
                 cyc, ddrRefresh, ddrWrite, ddrAddr, mOp.kind == K_REF, mOp.kind == K_DRAW, mOp.addr);
      end
      if (mOp.kind == K_DRAW) begin
        checks++;
        if (ddrData !== mOp.data) begin
          errors++; $display("FAIL ddrData cyc %0d got %h exp %h", cyc, ddrData, mOp.data);
        end
      end
    end
    checks++;
    if (vidAck !== expVidAck || drawAck !== expDrawAck) begin
      errors++; $display("FAIL acks cyc %0d got v=%b d=%b exp v=%b d=%b", cyc, vidAck, drawAck, expVidAck, expDrawAck);
    end
    checks++;
    if (vidValid !== expVidValid || vidData !== mVidData) begin
      errors++; $display("FAIL vid_return cyc %0d got valid=%b data=%h exp valid=%b data=%h",
                         cyc, vidValid, vidData, expVidValid, mVidData);
    end
    checks++;
    if (refreshOverrun !== mOverrun) begin
      errors++; $display("FAIL refreshOverrun cyc %0d got %b exp %b", cyc, refreshOverrun, mOverrun);
    end
    if (errors >= 50) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    if (ddrValid === 1'b1 && !prevValid) begin
      grantLog.push_back(ddrRefresh ? K_REF : (ddrWrite ? K_DRAW : K_VID));
      if (ddrRefresh === 1'b1) refCyc.push_back(cyc);
    end
    prevValid = (ddrValid === 1'b1);
    // requesters
    if (vidAck === 1'b1) begin
      vidReq = vidHold; vidAddr = AW'($urandom);
    end else if (!vidReq && vidRand && $urandom_range(3) == 0) begin
      vidReq = 1; vidAddr = AW'($urandom);
    end
    if (drawAck === 1'b1) begin
      drawReq = drawHold; drawAddr = AW'($urandom); drawData = $urandom;
    end else if (!drawReq && drawRand && $urandom_range(3) == 0) begin
      drawReq = 1; drawAddr = AW'($urandom); drawData = $urandom;
    end
    // controller
    ddrDone = 0;
    if (doneCnt > 0) begin
      doneCnt--;
      if (doneCnt == 0) begin ddrDone = 1; outstanding = 0; lastDoneCyc = cyc; end
    end else if (spurDone && !outstanding && $urandom_range(7) == 0) ddrDone = 1;
    ddrReady = (readyMode == 1) ? 1'b1 : (readyMode == 2) ? 1'($urandom_range(1)) : 1'b0;
    if (ddrValid === 1'b1 && ddrReady) begin doneCnt = doneDelay; outstanding = 1; end
    ddrReadData = rdFixed ? rdVal : $urandom;
    if (spurDone) doneDelay = $urandom_range(1, 4);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    vidRand = 0; drawRand = 0; vidHold = 0; drawHold = 0;
    step();
    while (!(!mIssued && !mWaiting && !mRefPend && !vidReq && !drawReq && outstanding == 0 &&
             (REF_INT - (nInit % REF_INT)) > 40) && n < 3000) begin
      step(); n++;
    end
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL quiet_timeout got busy exp idle"); end
  endtask

  task automatic test_reset();
    rst = 0; initComplete = 0;
    repeat (3) step();
    checks++;
    if ({vidAck, vidValid, drawAck, ddrValid, ddrWrite, ddrRefresh, refreshOverrun} !== 7'b0 ||
        vidData !== '0 || ddrAddr !== '0 || ddrData !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero output exp all zero");
    end
    rst = 1; vidReq = 1; vidAddr = 24'h00BEEF;
    repeat (5) step();
    checks++;
    if (ddrValid !== 1'b0 || vidAck !== 1'b0) begin
      errors++; $display("FAIL no_grant_before_init got valid=%b ack=%b exp 0 0", ddrValid, vidAck);
    end
    vidReq = 0;
  endtask

  task automatic test_refresh();
    readyMode = 1; doneDelay = 2;
    initComplete = 1;
    refCyc.delete();
    repeat (3200) step();
    checks++;
    if (refCyc.size() < 3) begin
      errors++; $display("FAIL refresh_count got %0d exp >=3", refCyc.size());
    end
    for (int i = 1; i < refCyc.size(); i++) begin
      checks++;
      if (refCyc[i] - refCyc[i-1] < REF_INT - 4 || refCyc[i] - refCyc[i-1] > REF_INT + 4) begin
        errors++; $display("FAIL refresh_interval got %0d exp %0d", refCyc[i] - refCyc[i-1], REF_INT);
      end
    end
    checks++;
    if (refreshOverrun !== 1'b0) begin
      errors++; $display("FAIL overrun_idle got %b exp 0", refreshOverrun);
    end
  endtask

  task automatic test_video_read();
    int t0, n;
    wait_quiet();
    readyMode = 1; doneDelay = 2; rdFixed = 1; rdVal = 32'hAAAA5555;
    vidAddr = 24'h000123; vidReq = 1; t0 = cyc;
    n = 0;
    do begin step(); n++; end while (vidAck !== 1'b1 && n < 8);
    checks++;
    if (vidAck !== 1'b1 || cyc != t0 + 1) begin
      errors++; $display("FAIL vid_ack_latency got cyc %0d exp %0d", cyc, t0 + 1);
    end
    checks++;
    if (ddrValid !== 1'b1 || ddrAddr !== 24'h000123 || ddrWrite !== 1'b0) begin
      errors++; $display("FAIL vid_issue got valid=%b addr=%h wr=%b exp 1 000123 0", ddrValid, ddrAddr, ddrWrite);
    end
    n = 0;
    do begin step(); n++; end while (vidValid !== 1'b1 && n < 20);
    checks++;
    if (vidValid !== 1'b1 || vidData !== 32'hAAAA5555 || lastDoneCyc != cyc - 1) begin
      errors++; $display("FAIL vid_data got valid=%b data=%h doneCyc=%0d exp 1 aaaa5555 %0d",
                         vidValid, vidData, lastDoneCyc, cyc - 1);
    end
    rdFixed = 0;
  endtask

  task automatic test_draw_write();
    int t0, n;
    bit sawVid;
    wait_quiet();
    readyMode = 1; doneDelay = 2; sawVid = 0;
    drawAddr = 24'h00ABCD; drawData = 32'h12345678; drawReq = 1; t0 = cyc;
    n = 0;
    do begin step(); n++; end while (drawAck !== 1'b1 && n < 8);
    checks++;
    if (drawAck !== 1'b1 || cyc != t0 + 1) begin
      errors++; $display("FAIL draw_ack_latency got cyc %0d exp %0d", cyc, t0 + 1);
    end
    checks++;
    if (ddrValid !== 1'b1 || ddrWrite !== 1'b1 || ddrAddr !== 24'h00ABCD || ddrData !== 32'h12345678) begin
      errors++; $display("FAIL draw_issue got wr=%b addr=%h data=%h exp 1 00abcd 12345678", ddrWrite, ddrAddr, ddrData);
    end
    repeat (8) begin step(); if (vidValid === 1'b1) sawVid = 1; end
    checks++;
    if (sawVid) begin errors++; $display("FAIL draw_no_vidValid got 1 exp 0"); end
  endtask

  task automatic test_starvation();
    int seq[$];
    int n;
    wait_quiet();
    readyMode = 2; spurDone = 1;
    vidHold = 1; drawHold = 1;
    vidReq = 1; vidAddr = AW'($urandom);
    drawReq = 1; drawAddr = AW'($urandom); drawData = $urandom;
    grantLog.delete();
    n = 0;
    while (seq.size() < 27 && n < 3000) begin
      step(); n++;
      while (grantLog.size() > 0) begin
        if (grantLog[0] != K_REF) seq.push_back(grantLog[0]);
        void'(grantLog.pop_front());
      end
    end
    checks++;
    if (seq.size() < 27) begin errors++; $display("FAIL starve_grants got %0d exp 27", seq.size()); end
    for (int i = 0; i < 27 && i < seq.size(); i++) begin
      checks++;
      if (seq[i] != ((i % 9 == 8) ? K_DRAW : K_VID)) begin
        errors++; $display("FAIL starve_order idx %0d got %0d exp %0d", i, seq[i], (i % 9 == 8) ? K_DRAW : K_VID);
      end
    end
    vidHold = 0; drawHold = 0; spurDone = 0;
  endtask

  task automatic test_random();
    int lowCnt;
    lowCnt = 0;
    wait_quiet();
    readyMode = 2; spurDone = 1; vidRand = 1; drawRand = 1;
    grantLog.delete();
    for (int i = 0; i < 4000; i++) begin
      step();
      if (lowCnt > 0) begin
        lowCnt--;
        if (lowCnt == 0) initComplete = 1;
      end else if ($urandom_range(599) == 0) begin
        initComplete = 0; lowCnt = $urandom_range(5, 30);
      end
    end
    initComplete = 1; spurDone = 0; readyMode = 1;
    checks++;
    if (grantLog.size() < 200) begin errors++; $display("FAIL random_activity got %0d grants exp >=200", grantLog.size()); end
  endtask

  task automatic test_stall();
    int n;
    wait_quiet();
    readyMode = 0; doneDelay = 2;
    vidReq = 1; vidAddr = AW'($urandom);
    repeat (2100) step();
    checks++;
    if (refreshOverrun !== 1'b1 || ddrValid !== 1'b1 || ddrRefresh !== 1'b0) begin
      errors++; $display("FAIL stall_overrun got ovr=%b valid=%b ref=%b exp 1 1 0", refreshOverrun, ddrValid, ddrRefresh);
    end
    vidReq = 1; vidAddr = AW'($urandom);
    drawReq = 1; drawAddr = AW'($urandom); drawData = $urandom;
    readyMode = 1;
    grantLog.delete();
    n = 0;
    while (grantLog.size() < 1 && n < 20) begin step(); n++; end
    checks++;
    if (grantLog.size() < 1 || grantLog[0] != K_REF) begin
      errors++; $display("FAIL refresh_first got %0d exp %0d", grantLog.size() > 0 ? grantLog[0] : -1, K_REF);
    end
  endtask

  task automatic test_reset_wait();
    int n;
    bit sawVid;
    wait_quiet();
    readyMode = 1; doneDelay = 8; sawVid = 0;
    vidReq = 1; vidAddr = AW'($urandom);
    n = 0;
    while (!mWaiting && n < 10) begin step(); n++; end
    rst = 0;
    step();
    rst = 1;
    checks++;
    if ({vidAck, vidValid, drawAck, ddrValid, ddrWrite, ddrRefresh, refreshOverrun} !== 7'b0 ||
        vidData !== '0 || ddrAddr !== '0 || ddrData !== '0) begin
      errors++; $display("FAIL reset_in_wait got nonzero output (ovr=%b valid=%b) exp all zero", refreshOverrun, ddrValid);
    end
    repeat (12) begin step(); if (vidValid === 1'b1) sawVid = 1; end
    checks++;
    if (sawVid) begin errors++; $display("FAIL late_done_vidValid got 1 exp 0"); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 0; initComplete = 0; vidReq = 0; drawReq = 0;
    vidAddr = '0; drawAddr = '0; drawData = '0;
    ddrReady = 0; ddrDone = 0; ddrReadData = '0;
    readyMode = 1; doneDelay = 2; spurDone = 0;
    vidHold = 0; drawHold = 0; vidRand = 0; drawRand = 0; rdFixed = 0; rdVal = '0;
    doneCnt = 0; lastDoneCyc = 0; outstanding = 0;
    mOp.kind = K_VID; mOp.addr = '0; mOp.data = '0;
    mIssued = 0; mWaiting = 0; mRefPend = 0; mOverrun = 0;
    expVidAck = 0; expDrawAck = 0; expVidValid = 0; mVidData = '0;
    nInit = 0; vidWhileDrawWaits = 0; prevValid = 0;
    test_reset();
    test_refresh();
    test_video_read();
    test_draw_write();
    test_starvation();
    test_random();
    test_stall();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
